// File: rtl/mac_round_sched_pkg.sv
// Shared defaults and FSM encoding for the MAC-lane rounding scheduler.
package mac_round_sched_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int DW_DEF    = 16;
    localparam int FRAC_DEF  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/round_hu_sat.sv
// Combinational round-half-up by FRAC bits with positive-overflow saturation.
module round_hu_sat #(
    parameter int DW   = 16,
    parameter int FRAC = 3
) (
    input  logic [DW-1:0] a_i,
    output logic [DW-1:0] result_o,
    output logic          sat_o
);

    localparam logic signed [DW:0] HALF    = (DW+1)'(1) << (FRAC-1);
    localparam logic signed [DW:0] MAX_POS = {2'b00, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]      MAX_RND = {{(FRAC+1){1'b0}}, {(DW-1-FRAC){1'b1}}};

    logic signed [DW:0]   sum;
    logic signed [DW-1:0] shifted;

    // One guard bit: only a positive input can overflow when adding the half LSB.
    assign sum      = $signed({a_i[DW-1], a_i}) + HALF;
    assign sat_o    = sum > MAX_POS;
    assign shifted  = $signed(sum[DW-1:0]) >>> FRAC;
    assign result_o = sat_o ? MAX_RND : shifted;

endmodule

// File: rtl/mac_round_sched.sv
// Round-robin arbiter feeding a shared round/saturate unit; 1-cycle registered result.
// A grant is only offered when the output slot is empty or draining this cycle.
module mac_round_sched
    import mac_round_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW    = DW_DEF,
    parameter int FRAC  = FRAC_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DW-1:0]      req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     out_valid,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(N_REQ)-1:0] out_lane,
    input  logic                     out_ready,
    output logic [15:0]              sat_cnt,
    input  logic                     sat_clr,
    output logic                     busy
);

    localparam int LW = $clog2(N_REQ);

    state_e          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [LW-1:0]   out_lane_q, out_lane_d;
    logic [LW-1:0]   last_grant_q, last_grant_d;
    logic [15:0]     sat_cnt_q, sat_cnt_d;

    logic            found;
    logic [LW-1:0]   gnt_idx;
    logic [LW-1:0]   cand;
    logic            slot_free;
    logic            xfer;
    logic [DW-1:0]   rnd_res;
    logic            rnd_sat;

    // Search starts one past the last winner so every lane gets a turn.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = LW'((int'(last_grant_q) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign slot_free = !out_valid_q || out_ready;
    assign xfer      = !rst && (state_q == ST_RUN) && en && slot_free && found;

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[gnt_idx] = 1'b1;
    end

    round_hu_sat #(.DW(DW), .FRAC(FRAC)) u_round (
        .a_i      (req_data[gnt_idx*DW +: DW]),
        .result_o (rnd_res),
        .sat_o    (rnd_sat)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (en) state_d = ST_RUN;
            ST_RUN:   if (!en) state_d = out_valid_q ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: begin
                if (en)                            state_d = ST_RUN;
                else if (!out_valid_q || out_ready) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_lane_d   = out_lane_q;
        last_grant_d = last_grant_q;
        sat_cnt_d    = sat_cnt_q;
        if (xfer) begin
            out_valid_d  = 1'b1;
            out_data_d   = rnd_res;
            out_lane_d   = gnt_idx;
            last_grant_d = gnt_idx;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
        // Clear beats a coincident saturation; the counter sticks at all-ones.
        if (sat_clr)
            sat_cnt_d = '0;
        else if (xfer && rnd_sat && sat_cnt_q != 16'hFFFF)
            sat_cnt_d = sat_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_lane_q   <= '0;
            last_grant_q <= LW'(N_REQ-1);
            sat_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_lane_q   <= out_lane_d;
            last_grant_q <= last_grant_d;
            sat_cnt_q    <= sat_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_lane  = out_lane_q;
    assign sat_cnt   = sat_cnt_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mac_round_sched.sv
// Directed bench for mac_round_sched; expected results queued at issue, checked by a monitor.
module tb_mac_round_sched;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_lane;
    logic        out_ready;
    logic [15:0] sat_cnt;
    logic        sat_clr;
    logic        busy;

    typedef struct packed {
        logic [1:0]  lane;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    mac_round_sched #(.N_REQ(4), .DW(16), .FRAC(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_ready (out_ready),
        .sat_cnt   (sat_cnt),
        .sat_clr   (sat_clr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [1:0] l, input logic [15:0] d);
        exp_q.push_back({l, d});
    endtask

    // Offer one operand on a single lane; it must be accepted this cycle.
    task automatic send(input int lane, input logic [15:0] d, input logic [15:0] r);
        req_valid = 4'(1 << lane);
        req_data[lane*16 +: 16] = d;
        @(negedge clk);
        chk("send_ready", {28'd0, req_ready}, 32'(1 << lane));
        expect_out(2'(lane), r);
        tick();
        req_valid = '0;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        en        = 1'b0;
        req_valid = '0;
        sat_clr   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual lane=%0d data=%h required none", out_lane, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_lane", {30'd0, out_lane}, {30'd0, mon_e.lane});
                chk("out_data", {16'd0, out_data}, {16'd0, mon_e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with everything asserted: nothing may be granted.
        rst = 1'b1; en = 1'b1; req_valid = 4'hF; out_ready = 1'b1;
        sat_clr = 1'b0; req_data = '0;
        tick();
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", {16'd0, out_data}, 0);
        chk("rst_out_lane", {30'd0, out_lane}, 0);
        chk("rst_sat_cnt", {16'd0, sat_cnt}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_req_ready", {28'd0, req_ready}, 0);
        tick();
        rst = 1'b0; en = 1'b1; req_valid = '0;
        tick();

        // Rounding: ties go up, negatives floor.
        send(0, 16'h0005, 16'h0001);
        send(0, 16'h0004, 16'h0001);
        send(0, 16'h0003, 16'h0000);
        send(0, 16'hFFFC, 16'h0000);
        send(0, 16'hFFFB, 16'hFFFF);
        @(negedge clk);
        chk("latency_valid", {31'd0, out_valid}, 1);
        tick();
        @(negedge clk);
        chk("drop_valid", {31'd0, out_valid}, 0);
        tick();

        // Round-robin with all lanes valid straight after reset.
        do_reset();
        req_data  = {16'd32, 16'd24, 16'd16, 16'd8};
        req_valid = 4'hF;
        en        = 1'b1;
        @(negedge clk);
        chk("idle_no_grant", {28'd0, req_ready}, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rr_grant", {28'd0, req_ready}, 32'(1 << (i % 4)));
            expect_out(2'(i % 4), 16'((i % 4) + 1));
            tick();
        end

        // Backpressure: output holds, no grants, then resume same cycle.
        @(negedge clk);
        chk("bp_grant", {28'd0, req_ready}, 32'h2);
        expect_out(2'd1, 16'd2);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, out_valid}, 1);
            chk("bp_data", {16'd0, out_data}, 32'd2);
            chk("bp_lane", {30'd0, out_lane}, 32'd1);
            chk("bp_ready_zero", {28'd0, req_ready}, 0);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume", {28'd0, req_ready}, 32'h4);
        expect_out(2'd2, 16'd3);
        tick();
        req_valid = '0;

        // Saturation counting and clear priority.
        send(2, 16'h7FFE, 16'h0FFF);
        @(negedge clk);
        chk("sat_cnt_one", {16'd0, sat_cnt}, 1);
        tick();
        sat_clr = 1'b1;
        send(2, 16'h7FFF, 16'h0FFF);
        sat_clr = 1'b0;
        @(negedge clk);
        chk("sat_clr_wins", {16'd0, sat_cnt}, 0);
        tick();
        send(2, 16'h7FFB, 16'h0FFF);
        send(2, 16'h8000, 16'hF000);
        @(negedge clk);
        chk("no_sat_edge", {16'd0, sat_cnt}, 0);
        tick();

        // Disable while stalled: drain, then idle.
        req_data[63:48] = 16'h0010;
        req_valid = 4'b1000;
        out_ready = 1'b0;
        @(negedge clk);
        chk("drain_grant", {28'd0, req_ready}, 32'h8);
        expect_out(2'd3, 16'd2);
        tick();
        en = 1'b0;
        req_valid = 4'hF;
        @(negedge clk);
        chk("en_low_ready", {28'd0, req_ready}, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("drain_busy", {31'd0, busy}, 1);
            chk("drain_ready", {28'd0, req_ready}, 0);
            chk("drain_valid", {31'd0, out_valid}, 1);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_ready2", {28'd0, req_ready}, 0);
        tick();
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_valid", {31'd0, out_valid}, 0);
        tick();

        // Reset while a result is held: it is discarded, lane 0 wins next.
        req_valid = '0;
        en = 1'b1;
        tick();
        out_ready = 1'b0;
        req_data[31:16] = 16'h7FFE;
        req_valid = 4'b0010;
        @(negedge clk);
        chk("pre_rst_grant", {28'd0, req_ready}, 32'h2);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("pre_rst_sat", {16'd0, sat_cnt}, 1);
        chk("pre_rst_valid", {31'd0, out_valid}, 1);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        req_valid = 4'hF;
        req_data[15:0] = 16'h0028;
        #1;
        chk("rst_ready_zero", {28'd0, req_ready}, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", {31'd0, out_valid}, 0);
        chk("post_rst_sat", {16'd0, sat_cnt}, 0);
        chk("post_rst_busy", {31'd0, busy}, 0);
        tick();
        @(negedge clk);
        chk("post_rst_lane0", {28'd0, req_ready}, 32'h1);
        expect_out(2'd0, 16'd5);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_round_sched.md
MAC_ROUND_SCHED -- requirements
Module: mac_round_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of MAC-lane requesters sharing the rounding unit.
REQ-002 Parameter DW, default 16, signed two's-complement data width.
REQ-003 Parameter FRAC, default 3, fractional bits removed by round-half-up.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en  input  1  scheduler enable; low blocks new grants.
REQ-007 req_valid  input  N_REQ  per-lane operand valid.
REQ-008 req_data  input  N_REQ*DW  per-lane signed accumulator value; lane i occupies bits [i*DW +: DW].
REQ-009 req_ready  output  N_REQ  per-lane accept, one-hot or zero.
REQ-010 out_valid  output  1  rounded result valid.
REQ-011 out_data  output  DW  rounded, sign-extended result.
REQ-012 out_lane  output  clog2(N_REQ)  source lane of out_data.
REQ-013 out_ready  input  1  downstream accept.
REQ-014 sat_cnt  output  16  saturation event counter.
REQ-015 sat_clr  input  1  synchronous clear of sat_cnt.
REQ-016 busy  output  1  high when state is not IDLE.

Function
REQ-017 Rounding SHALL be round(a) = (a + 2^(FRAC-1)) >>> FRAC, using an arithmetic shift, so ties round toward +infinity.
REQ-018 Rounding SHALL compute the sum a + 2^(FRAC-1) at DW+1 bits; if it exceeds 2^(DW-1)-1, out_data SHALL be (2^(DW-1)-1) >>> FRAC, and the event SHALL be flagged as a saturation.
REQ-019 The slot SHALL be free when !out_valid || out_ready.
REQ-020 A grant SHALL be issued only in state RUN with en high and the slot free.
REQ-021 The grant SHALL go to the first lane with req_valid high, searching round-robin from last_grant+1 modulo N_REQ.
REQ-022 req_ready SHALL be the combinational one-hot grant.
REQ-023 req_ready SHALL never be high for a lane whose req_valid is low.
REQ-024 A transfer SHALL occur when req_valid[i] && req_ready[i] are both high.
REQ-025 On a transfer, last_grant SHALL update to i, and out_data, out_lane and out_valid=1 SHALL be registered at the next edge (latency 1 cycle).
REQ-026 While out_valid && !out_ready, out_data and out_lane SHALL hold stable and req_ready SHALL be all-zero.
REQ-027 A back-to-back transfer SHALL be permitted in the cycle out_ready drains the register, giving 1 result per cycle sustained.
REQ-028 out_valid SHALL drop at the edge where out_ready is high and no new transfer occurs.
REQ-029 FSM states: IDLE, RUN, DRAIN.
REQ-030 FSM transitions: IDLE->RUN when en=1; RUN->DRAIN when en=0 && out_valid; RUN->IDLE when en=0 && !out_valid; DRAIN->IDLE when out_valid drains; DRAIN->RUN when en=1.
REQ-031 sat_cnt SHALL increment by 1 on each transfer flagged as a saturation, and SHALL stick at 0xFFFF.
REQ-032 When sat_clr coincides with a saturation event, the clear SHALL win and sat_cnt SHALL become 0.

Reset
REQ-033 While rst is high at a clock edge, the block SHALL set state=IDLE, out_valid=0, out_data=0, out_lane=0, sat_cnt=0 and last_grant=N_REQ-1 (lane 0 highest priority first).
REQ-034 Reset asserted mid-transfer SHALL discard the held result without emitting it.
REQ-035 req_ready SHALL be 0 during reset.

Structure
REQ-036 A shared package SHALL hold DW, FRAC, N_REQ defaults and the FSM state encoding (IDLE=0, RUN=1, DRAIN=2).
REQ-037 The rounding arithmetic SHALL be one combinational sub-module, round_hu_sat (DW and FRAC parameters, outputs result and sat flag), fed by the granted lane's data.
REQ-038 Arbitration, FSM, output register and counter SHALL reside in mac_round_sched.

Verification (DW=16, FRAC=3, N_REQ=4)
REQ-039 Lane 0 sends 0x0005, 0x0004, 0x0003, 0xFFFC, 0xFFFB with out_ready=1 -> outputs 0x0001, 0x0001, 0x0000, 0x0000, 0xFFFF, each 1 cycle after its transfer.
REQ-040 All four lanes continuously valid after reset with en=1 -> grants 0,1,2,3,0, one per cycle, and out_lane follows the same sequence.
REQ-041 out_ready held 0 for 3 cycles with out_valid=1 -> out_data and out_lane stable and req_ready=0 throughout; then out_ready=1 -> the next lane is accepted in the same cycle.
REQ-042 Lane 2 sends 0x7FFE -> out_data=0x0FFF and sat_cnt=1; a following sat_clr coinciding with another saturation -> sat_cnt=0.
REQ-043 en drops while out_valid && !out_ready -> state=DRAIN with no grants; out_ready=1 -> state=IDLE and busy=0.
REQ-044 rst pulsed while out_valid=1 -> next cycle out_valid=0 and sat_cnt=0, and the first later grant goes to lane 0.
